// File: rtl/pim_pkg.sv
// Shared types and helpers for the PIM issue controller: FSM states and funct3 decoding.
package pim_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } pim_state_e;

  localparam logic [2:0] PIM_ST  = 3'b000;
  localparam logic [2:0] PIM_LD  = 3'b001;
  localparam logic [2:0] PIM_MAC = 3'b010;

  function automatic logic pim_needs_wb(input logic [2:0] funct3);
    return (funct3 == PIM_LD) || (funct3 == PIM_MAC);
  endfunction

  function automatic logic pim_is_legal(input logic [2:0] funct3);
    return (funct3 == PIM_ST) || (funct3 == PIM_LD) || (funct3 == PIM_MAC);
  endfunction

endpackage

// File: rtl/pim_issue_ctrl.sv
// Issues PIM instructions from ID to the external PIM unit, stalls the front end while
// the op is outstanding and returns LD/MAC results as a one-cycle writeback pulse.
`ifndef OPCODE_PIM
`define OPCODE_PIM 7'b0001011
`endif

module pim_issue_ctrl
  import pim_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        illegal_o,
  output logic        pim_req_valid_o,
  input  logic        pim_req_ready_i,
  output logic [2:0]  pim_req_op_o,
  output logic [31:0] pim_req_addr_o,
  output logic [31:0] pim_req_wdata_o,
  input  logic        pim_rsp_valid_i,
  input  logic [31:0] pim_rsp_data_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  pim_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             illegal_q, illegal_d;
  logic             err_q, err_d;
  logic             wb_vld_q, wb_vld_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic hit;
  logic timeout_hit;

  assign hit         = id_valid_i & (opcode_i == `OPCODE_PIM) & ~flush_i;
  assign timeout_hit = TO_EN & (cnt_q == CNT_LAST);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    kill_d          = kill_q;
    op_d            = op_q;
    rd_d            = rd_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    illegal_d       = 1'b0;
    err_d           = 1'b0;
    wb_vld_d        = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    stall_o         = 1'b0;
    pim_req_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (hit) begin
          if (pim_is_legal(funct3_i)) begin
            op_d    = funct3_i;
            rd_d    = rd_i;
            addr_d  = rs1_data_i + imm_i;
            wdata_d = rs2_data_i;
            stall_o = 1'b1;
            state_d = ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        pim_req_valid_o = 1'b1;
        stall_o         = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (pim_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d   = cnt_q + 1'b1;
        stall_o = ~pim_rsp_valid_i & ~timeout_hit;
        if (flush_i) kill_d = 1'b1;
        // A response wins over a timeout landing in the same cycle.
        if (pim_rsp_valid_i) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (pim_needs_wb(op_q) && (rd_q != 5'd0) && !kill_q && !flush_i) begin
            wb_vld_d  = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = pim_rsp_data_i;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
      wb_vld_q  <= wb_vld_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign illegal_o       = illegal_q;
  assign err_o           = err_q;
  assign pim_req_op_o    = op_q;
  assign pim_req_addr_o  = addr_q;
  assign pim_req_wdata_o = wdata_q;
  assign wb_valid_o      = wb_vld_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_pim_issue_ctrl.sv
// Directed bench for pim_issue_ctrl: load/store/MAC paths, timeout, flush, illegal, back-to-back, reset.
`ifndef OPCODE_PIM
`define OPCODE_PIM 7'b0001011
`endif

module tb_pim_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic        flush_i;
  logic        stall_o, illegal_o;
  logic        pim_req_valid_o, pim_req_ready_i;
  logic [2:0]  pim_req_op_o;
  logic [31:0] pim_req_addr_o, pim_req_wdata_o;
  logic        pim_rsp_valid_i;
  logic [31:0] pim_rsp_data_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pim_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .flush_i(flush_i),
    .stall_o(stall_o), .illegal_o(illegal_o),
    .pim_req_valid_o(pim_req_valid_o), .pim_req_ready_i(pim_req_ready_i),
    .pim_req_op_o(pim_req_op_o), .pim_req_addr_o(pim_req_addr_o), .pim_req_wdata_o(pim_req_wdata_o),
    .pim_rsp_valid_i(pim_rsp_valid_i), .pim_rsp_data_i(pim_rsp_data_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle away from it.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic id_clear();
    id_valid_i = 1'b0; opcode_i = 7'd0; funct3_i = 3'd0; rd_i = 5'd0;
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; imm_i = 32'd0;
  endtask

  task automatic id_pim(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm);
    id_valid_i = 1'b1; opcode_i = `OPCODE_PIM; funct3_i = f3; rd_i = rd;
    rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; pim_req_ready_i = 1'b0;
    pim_rsp_valid_i = 1'b0; pim_rsp_data_i = 32'd0;
    id_clear();

    // Reset state
    cyc(); cyc();
    chk("rst_stall", stall_o, 0);
    chk("rst_req_valid", pim_req_valid_o, 0);
    chk("rst_req_addr", pim_req_addr_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_illegal", illegal_o, 0);
    rst_i = 1'b0;
    cyc();

    // PIM_LD: addr wraps to 0xFFC, response two cycles after handshake
    id_pim(3'b001, 5'd5, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC);
    settle();
    chk("ld_c0_stall", stall_o, 1);
    chk("ld_c0_req_valid", pim_req_valid_o, 0);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    settle();
    chk("ld_c1_req_valid", pim_req_valid_o, 1);
    chk("ld_c1_addr", pim_req_addr_o, 32'h0000_0FFC);
    chk("ld_c1_op", pim_req_op_o, 3'b001);
    chk("ld_c1_stall", stall_o, 1);
    cyc();
    pim_req_ready_i = 1'b0;
    settle();
    chk("ld_c2_stall", stall_o, 1);
    chk("ld_c2_req_valid", pim_req_valid_o, 0);
    cyc();
    pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'hDEAD_BEEF;
    settle();
    chk("ld_c3_stall", stall_o, 0);
    cyc();
    pim_rsp_valid_i = 1'b0; pim_rsp_data_i = 32'h0;
    settle();
    chk("ld_wb_valid", wb_valid_o, 1);
    chk("ld_wb_rd", wb_rd_o, 5);
    chk("ld_wb_data", wb_data_o, 32'hDEAD_BEEF);
    cyc();
    chk("ld_wb_pulse_end", wb_valid_o, 0);

    // PIM_ST: ready held low 3 cycles, request held stable
    id_pim(3'b000, 5'd4, 32'hFFFF_FFF0, 32'hCAFE_F00D, 32'h0000_0020);
    cyc();
    id_clear();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_hold_valid", pim_req_valid_o, 1);
      chk("st_hold_addr", pim_req_addr_o, 32'h0000_0010);
      chk("st_hold_wdata", pim_req_wdata_o, 32'hCAFE_F00D);
      chk("st_hold_stall", stall_o, 1);
      cyc();
    end
    pim_req_ready_i = 1'b1;
    settle();
    chk("st_hs_valid", pim_req_valid_o, 1);
    cyc();
    pim_req_ready_i = 1'b0; pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'h1234_5678;
    settle();
    chk("st_rsp_wb", wb_valid_o, 0);
    cyc();
    pim_rsp_valid_i = 1'b0;
    settle();
    chk("st_no_wb", wb_valid_o, 0);
    chk("st_idle_stall", stall_o, 0);

    // Timeout with TIMEOUT_CYCLES=4
    id_pim(3'b001, 5'd3, 32'h100, 32'h0, 32'h0);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    cyc();
    pim_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("to_wait_stall", stall_o, 1);
      cyc();
    end
    settle();
    chk("to_w4_stall", stall_o, 0);
    chk("to_w4_err_pre", err_o, 0);
    cyc();
    chk("to_err", err_o, 1);
    chk("to_wb", wb_valid_o, 0);
    cyc();
    chk("to_err_pulse_end", err_o, 0);
    // Next instruction issues normally with a zero-wait response
    id_pim(3'b001, 5'd9, 32'h400, 32'h0, 32'h8);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    settle();
    chk("to_next_valid", pim_req_valid_o, 1);
    chk("to_next_addr", pim_req_addr_o, 32'h0000_0408);
    cyc();
    pim_req_ready_i = 1'b0; pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'h0000_A5A5;
    cyc();
    pim_rsp_valid_i = 1'b0;
    settle();
    chk("to_next_wb_valid", wb_valid_o, 1);
    chk("to_next_wb_rd", wb_rd_o, 9);
    chk("to_next_wb_data", wb_data_o, 32'h0000_A5A5);
    chk("to_next_err", err_o, 0);
    cyc();

    // Flush during WAIT_RSP kills the writeback of a MAC
    id_pim(3'b010, 5'd7, 32'h20, 32'h3, 32'h0);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    cyc();
    pim_req_ready_i = 1'b0; flush_i = 1'b1;
    settle();
    chk("fl_wait_stall", stall_o, 1);
    cyc();
    flush_i = 1'b0; pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'h77;
    cyc();
    pim_rsp_valid_i = 1'b0;
    settle();
    chk("fl_killed_wb", wb_valid_o, 0);
    // MAC to rd=0 never writes back
    id_pim(3'b010, 5'd0, 32'h20, 32'h3, 32'h0);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    cyc();
    pim_req_ready_i = 1'b0; pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'h88;
    cyc();
    pim_rsp_valid_i = 1'b0;
    settle();
    chk("rd0_wb", wb_valid_o, 0);
    // Flush in IDLE blocks the hit
    id_pim(3'b001, 5'd6, 32'h0, 32'h0, 32'h0); flush_i = 1'b1;
    settle();
    chk("fl_idle_stall", stall_o, 0);
    cyc();
    id_clear(); flush_i = 1'b0;
    settle();
    chk("fl_idle_no_req", pim_req_valid_o, 0);

    // Illegal funct3
    id_pim(3'b111, 5'd2, 32'h0, 32'h0, 32'h0);
    settle();
    chk("ill_stall", stall_o, 0);
    cyc();
    id_clear();
    settle();
    chk("ill_pulse", illegal_o, 1);
    chk("ill_req_valid", pim_req_valid_o, 0);
    chk("ill_stall_after", stall_o, 0);
    cyc();
    chk("ill_pulse_end", illegal_o, 0);

    // Back-to-back: second LD accepted in the first one's writeback cycle
    id_pim(3'b001, 5'd1, 32'h1000, 32'h0, 32'h0);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    cyc();
    pim_req_ready_i = 1'b0; pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'h0000_0111;
    cyc();
    pim_rsp_valid_i = 1'b0;
    id_pim(3'b001, 5'd2, 32'h2000, 32'h0, 32'h4);
    settle();
    chk("b2b_wb_valid", wb_valid_o, 1);
    chk("b2b_wb_data", wb_data_o, 32'h0000_0111);
    chk("b2b_second_stall", stall_o, 1);
    cyc();
    id_clear(); pim_req_ready_i = 1'b1;
    settle();
    chk("b2b_second_valid", pim_req_valid_o, 1);
    chk("b2b_second_addr", pim_req_addr_o, 32'h0000_2004);
    chk("b2b_wb_end", wb_valid_o, 0);
    cyc();
    pim_req_ready_i = 1'b0;
    settle();
    chk("b2b_wait_stall", stall_o, 1);
    // Reset mid-WAIT_RSP abandons the op
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    settle();
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_req_valid", pim_req_valid_o, 0);
    chk("mid_rst_addr", pim_req_addr_o, 0);
    chk("mid_rst_op", pim_req_op_o, 0);
    chk("mid_rst_wb_valid", wb_valid_o, 0);
    chk("mid_rst_wb_rd", wb_rd_o, 0);
    // A stray response in IDLE is ignored
    pim_rsp_valid_i = 1'b1; pim_rsp_data_i = 32'h0000_0999;
    cyc();
    pim_rsp_valid_i = 1'b0;
    settle();
    chk("stray_rsp_wb", wb_valid_o, 0);
    chk("stray_rsp_req", pim_req_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
